// File: rtl/pds_switch.sv
// Packet switch core: routes {source, target, data} packets from one upstream
// port into per-output FIFOs, each drained through its own valid/ready port.
module pds_switch #(
    parameter int unsigned SRC_W     = 4,
    parameter int unsigned TGT_W     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DROP_SELF = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [SRC_W+TGT_W+DATA_W-1:0]                 data_ip,
    input  logic                                          valid_up,
    output logic                                          ready_up,
    output logic [NUM_PORTS*(SRC_W+TGT_W+DATA_W)-1:0]     data_op,
    output logic [NUM_PORTS-1:0]                          valid_op,
    input  logic [NUM_PORTS-1:0]                          ready_op,
    output logic                                          drop_pulse,
    output logic [CNT_W-1:0]                              drop_cnt
);
    localparam int unsigned PKT_W = SRC_W + TGT_W + DATA_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CMP_W = (SRC_W > TGT_W) ? SRC_W : TGT_W;

    logic [SRC_W-1:0]     src;
    logic [TGT_W-1:0]     tgt;
    logic                 illegal;
    logic                 tgt_full;
    logic                 accept;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] push;

    assign src = data_ip[PKT_W-1 -: SRC_W];
    assign tgt = data_ip[DATA_W +: TGT_W];

    // Classify the packet on data_ip and look up the fullness of its target queue
    always_comb begin
        illegal  = (32'(tgt) >= NUM_PORTS) ||
                   ((DROP_SELF != 0) && (CMP_W'(src) == CMP_W'(tgt)));
        tgt_full = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (32'(tgt) == p) begin
                tgt_full = full[p];
            end
        end
    end

    // Space is judged on registered occupancy only; a same-cycle pop never frees it
    assign ready_up = !reset && (illegal || !tgt_full);
    assign accept   = valid_up && ready_up;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [PKT_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [OCC_W-1:0] occ;
        logic             pop;

        assign push[p]     = accept && !illegal && (32'(tgt) == 32'(p));
        assign pop         = valid_op[p] && ready_op[p] && !reset;
        assign full[p]     = (occ == OCC_W'(DEPTH));
        assign valid_op[p] = (occ != '0);
        assign data_op[p*PKT_W +: PKT_W] = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push[p]) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                occ <= occ + OCC_W'(push[p]) - OCC_W'(pop);
            end
        end

        // Storage is left unreset; occupancy alone decides what is visible
        always_ff @(posedge clk) begin
            if (push[p]) begin
                mem[wr_ptr] <= data_ip;
            end
        end
    end

    // Drop reporting: one-cycle pulse plus a saturating total
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= accept && illegal;
            if (accept && illegal && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pds_switch.sv
// Self-checking bench for pds_switch: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_pds_switch;
    localparam int unsigned NP      = 4;
    localparam int unsigned QDEPTH  = 4;
    localparam int          CNT_MAX = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [15:0]    data_ip;
    logic           valid_up;
    logic           ready_up;
    logic [NP*16-1:0] data_op;
    logic [NP-1:0]  valid_op;
    logic [NP-1:0]  ready_op;
    logic           drop_pulse;
    logic [1:0]     drop_cnt;

    pds_switch #(
        .SRC_W(4), .TGT_W(4), .DATA_W(8), .NUM_PORTS(NP),
        .DEPTH(QDEPTH), .DROP_SELF(1), .CNT_W(2)
    ) dut (
        .clk(clk), .reset(reset), .data_ip(data_ip), .valid_up(valid_up),
        .ready_up(ready_up), .data_op(data_op), .valid_op(valid_op),
        .ready_op(ready_op), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per port, a drop total and the pending pulse
    logic [15:0] mq [NP][$];
    int          m_cnt;
    bit          m_pulse;

    function automatic logic [15:0] pkt(input int s, input int t, input int d);
        return {4'(s), 4'(t), 8'(d)};
    endfunction

    function automatic bit m_illegal(input logic [15:0] p);
        return (p[11:8] >= 4'(NP)) || (p[15:12] == p[11:8]);
    endfunction

    function automatic bit m_ready(input logic [15:0] p);
        if (reset) return 1'b0;
        if (m_illegal(p)) return 1'b1;
        return mq[p[11:8]].size() < QDEPTH;
    endfunction

    task automatic drive(input logic [15:0] p, input logic v, input logic [NP-1:0] r);
        data_ip  = p;
        valid_up = v;
        ready_op = r;
        #1;
    endtask

    task automatic tick();
        bit acc;
        bit ill;
        acc = valid_up && m_ready(data_ip);
        ill = m_illegal(data_ip);
        @(posedge clk);
        if (reset) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
            m_cnt   = 0;
            m_pulse = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++)
                if (ready_op[p] && mq[p].size() > 0) void'(mq[p].pop_front());
            m_pulse = acc && ill;
            if (acc && ill) begin
                if (m_cnt < CNT_MAX) m_cnt++;
            end else if (acc) begin
                mq[data_ip[11:8]].push_back(data_ip);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(16'h0000, 1'b0, '0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(pkt(1, 2, 5), 1'b1, 4'hF);
        n_tests++;
        if (ready_up !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_up); end
        tick();
        tick();
        n_tests++;
        if (valid_op !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", valid_op); end
        n_tests++;
        if (drop_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", drop_cnt); end
        n_tests++;
        if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", drop_pulse); end
        reset = 1'b0;
        drive(pkt(1, 2, 5), 1'b0, '0);
        n_tests++;
        if (ready_up !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", ready_up); end
    endtask

    task automatic test_single();
        drive(pkt(1, 2, 8'hA5), 1'b1, '0);
        n_tests++;
        if (ready_up !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", ready_up); end
        tick();
        drive(16'h0000, 1'b0, '0);
        n_tests++;
        if (valid_op !== 4'b0100) begin n_fail++; $display("FAIL single_valid: got %b expected 0100", valid_op); end
        n_tests++;
        if (data_op[47:32] !== 16'h12A5) begin n_fail++; $display("FAIL single_data: got %h expected 12a5", data_op[47:32]); end
        drive(16'h0000, 1'b0, 4'b0100);
        tick();
        n_tests++;
        if (valid_op !== 4'b0000) begin n_fail++; $display("FAIL single_pop: got %b expected 0000", valid_op); end
    endtask

    task automatic test_backpressure();
        int exp_v;
        for (int i = 1; i <= 4; i++) begin
            drive(pkt(1, 0, i), 1'b1, '0);
            n_tests++;
            if (ready_up !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready[%0d]: got %b expected 1", i, ready_up); end
            tick();
        end
        drive(pkt(1, 0, 5), 1'b1, '0);
        n_tests++;
        if (ready_up !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", ready_up); end
        tick();
        n_tests++;
        if (ready_up !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: got %b expected 0", ready_up); end
        exp_v = 1;
        drive(pkt(1, 0, 5), 1'b1, 4'b0001);
        n_tests++;
        if (ready_up !== 1'b0) begin n_fail++; $display("FAIL bp_pop_no_space: got %b expected 0", ready_up); end
        n_tests++;
        if (data_op[15:0] !== pkt(1, 0, exp_v)) begin n_fail++; $display("FAIL bp_head: got %h expected %h", data_op[15:0], pkt(1, 0, exp_v)); end
        exp_v++;
        tick();
        drive(pkt(1, 0, 5), 1'b1, 4'b0001);
        n_tests++;
        if (ready_up !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b expected 1", ready_up); end
        n_tests++;
        if (data_op[15:0] !== pkt(1, 0, exp_v)) begin n_fail++; $display("FAIL bp_head: got %h expected %h", data_op[15:0], pkt(1, 0, exp_v)); end
        exp_v++;
        tick();
        for (int i = 0; i < 10 && valid_op[0]; i++) begin
            drive(16'h0000, 1'b0, 4'b0001);
            n_tests++;
            if (data_op[15:0] !== pkt(1, 0, exp_v)) begin n_fail++; $display("FAIL bp_head: got %h expected %h", data_op[15:0], pkt(1, 0, exp_v)); end
            exp_v++;
            tick();
        end
        n_tests++;
        if (exp_v !== 6) begin n_fail++; $display("FAIL bp_count: got %0d entries expected 5", exp_v - 1); end
        n_tests++;
        if (valid_op !== 4'b0000) begin n_fail++; $display("FAIL bp_drained: got %b expected 0000", valid_op); end
    endtask

    task automatic test_drop();
        logic [15:0] pk [3];
        bit          ep [3];
        int          ec [3];
        pk = '{pkt(0, 7, 8'h11), pkt(3, 3, 8'h22), pkt(1, 3, 8'h33)};
        ep = '{1'b1, 1'b1, 1'b0};
        ec = '{1, 2, 2};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(pk[i], 1'b1, '0);
            n_tests++;
            if (ready_up !== 1'b1) begin n_fail++; $display("FAIL drop_ready[%0d]: got %b expected 1", i, ready_up); end
            tick();
            n_tests++;
            if (drop_pulse !== ep[i]) begin n_fail++; $display("FAIL drop_pulse[%0d]: got %b expected %b", i, drop_pulse, ep[i]); end
            n_tests++;
            if (drop_cnt !== 2'(ec[i])) begin n_fail++; $display("FAIL drop_cnt[%0d]: got %0d expected %0d", i, drop_cnt, ec[i]); end
        end
        drive(16'h0000, 1'b0, '0);
        n_tests++;
        if (valid_op !== 4'b1000) begin n_fail++; $display("FAIL drop_valid: got %b expected 1000", valid_op); end
        n_tests++;
        if (data_op[63:48] !== 16'h1333) begin n_fail++; $display("FAIL drop_data: got %h expected 1333", data_op[63:48]); end
        tick();
        n_tests++;
        if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_idle: got %b expected 0", drop_pulse); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(pkt(2, 1, 0), 1'b1, '0);
        tick();
        drive(pkt(2, 1, 1), 1'b1, '0);
        tick();
        for (int k = 2; k < 12; k++) begin
            drive(pkt(2, 1, k), 1'b1, 4'b0010);
            n_tests++;
            if (ready_up !== 1'b1) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b expected 1", k, ready_up); end
            n_tests++;
            if (valid_op[1] !== 1'b1 || data_op[31:16] !== pkt(2, 1, k - 2)) begin
                n_fail++; $display("FAIL wrap_head[%0d]: got v=%b %h expected v=1 %h", k, valid_op[1], data_op[31:16], pkt(2, 1, k - 2));
            end
            tick();
        end
        for (int j = 10; j < 12; j++) begin
            drive(16'h0000, 1'b0, 4'b0010);
            n_tests++;
            if (valid_op[1] !== 1'b1 || data_op[31:16] !== pkt(2, 1, j)) begin
                n_fail++; $display("FAIL wrap_drain[%0d]: got v=%b %h expected v=1 %h", j, valid_op[1], data_op[31:16], pkt(2, 1, j));
            end
            tick();
        end
        n_tests++;
        if (valid_op !== 4'b0000) begin n_fail++; $display("FAIL wrap_empty: got %b expected 0000", valid_op); end
    endtask

    task automatic test_saturate();
        int ec [5];
        ec = '{1, 2, 3, 3, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(pkt(0, 9, i), 1'b1, '0);
            tick();
            n_tests++;
            if (drop_cnt !== 2'(ec[i])) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, drop_cnt, ec[i]); end
            n_tests++;
            if (drop_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_pulse[%0d]: got %b expected 1", i, drop_pulse); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(pkt(1, 0, 8'h40 + i), 1'b1, '0);
            tick();
            drive(pkt(2, 3, 8'h70 + i), 1'b1, '0);
            tick();
        end
        drive(pkt(0, 8, 0), 1'b1, '0);
        tick();
        n_tests++;
        if (valid_op !== 4'b1001 || drop_cnt !== 2'd1) begin
            n_fail++; $display("FAIL mid_setup: got %b cnt=%0d expected 1001 cnt=1", valid_op, drop_cnt);
        end
        reset = 1'b1;
        drive(pkt(1, 2, 8'hEE), 1'b1, 4'hF);
        n_tests++;
        if (ready_up !== 1'b0) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b expected 0", ready_up); end
        tick();
        reset = 1'b0;
        drive(pkt(1, 2, 8'hBE), 1'b1, '0);
        n_tests++;
        if (valid_op !== 4'b0000) begin n_fail++; $display("FAIL mid_valid: got %b expected 0000", valid_op); end
        n_tests++;
        if (drop_cnt !== 2'd0 || drop_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_drop: got cnt=%0d pulse=%b expected 0 0", drop_cnt, drop_pulse); end
        n_tests++;
        if (ready_up !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", ready_up); end
        tick();
        drive(16'h0000, 1'b0, '0);
        n_tests++;
        if (valid_op !== 4'b0100 || data_op[47:32] !== 16'h12BE) begin
            n_fail++; $display("FAIL mid_fresh: got %b %h expected 0100 12be", valid_op, data_op[47:32]);
        end
    endtask

    task automatic test_random();
        int          s;
        int          t;
        logic [NP-1:0] r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            s = $urandom_range(0, 15);
            t = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            r = (c < 200) ? NP'($urandom & $urandom) : NP'($urandom | $urandom);
            drive(pkt(s, t, $urandom), ($urandom_range(0, 3) != 0), r);
            n_tests++;
            if (ready_up !== m_ready(data_ip)) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, ready_up, m_ready(data_ip));
            end
            tick();
            n_tests++;
            if (drop_pulse !== m_pulse || drop_cnt !== 2'(m_cnt)) begin
                n_fail++; $display("FAIL rnd_drop[%0d]: got pulse=%b cnt=%0d expected pulse=%b cnt=%0d", c, drop_pulse, drop_cnt, m_pulse, m_cnt);
            end
            for (int p = 0; p < NP; p++) begin
                n_tests++;
                if (valid_op[p] !== (mq[p].size() > 0)) begin
                    n_fail++; $display("FAIL rnd_valid[%0d] port %0d: got %b expected %b", c, p, valid_op[p], mq[p].size() > 0);
                end else if (mq[p].size() > 0 && data_op[p*16 +: 16] !== mq[p][0]) begin
                    n_fail++; $display("FAIL rnd_data[%0d] port %0d: got %h expected %h", c, p, data_op[p*16 +: 16], mq[p][0]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        data_ip  = '0;
        valid_up = 1'b0;
        ready_op = '0;
        m_cnt    = 0;
        m_pulse  = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_drop();
        test_wrap();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pds_switch.md
Name: pds_switch

Overview:
- Parametrised next-generation packet data switch core.
- Accepts packets formatted {source, target, data} on one upstream port and queues each in a per-output FIFO selected by the target field.
- Presents each queue on its own valid/ready output port.
- Adds upstream back-pressure, illegal-target and self-addressed drop handling, and a saturating drop counter.

Parameters:
- SRC_W, 4, width of source field.
- TGT_W, 4, width of target field.
- DATA_W, 8, width of payload field.
- NUM_PORTS, 4, number of output ports; legal targets are 0..NUM_PORTS-1; must be at most 2**TGT_W.
- DEPTH, 4, entries per output FIFO; power of two, at least 2.
- DROP_SELF, 0, when 1, packets with source == target are dropped.
- CNT_W, 16, width of drop counter.

Derived: PKT_W = SRC_W+TGT_W+DATA_W (16 at defaults).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_ip  input  PKT_W  upstream packet, {source[PKT_W-1 -: SRC_W], target[next TGT_W], data[DATA_W-1:0]}.
- valid_up  input  1  upstream packet valid.
- ready_up  output  1  switch can accept the packet currently on data_ip.
- data_op  output  NUM_PORTS*PKT_W  port p head packet at bits [p*PKT_W +: PKT_W].
- valid_op  output  NUM_PORTS  port p head valid.
- ready_op  input  NUM_PORTS  port p downstream ready.
- drop_pulse  output  1  one-cycle pulse when an accepted packet is dropped.
- drop_cnt  output  CNT_W  total dropped packets, saturating.

Behaviour:
- Clock and reset: single clock domain clk; reset is synchronous and active-high.
- Reset effects (reset sampled high at a rising edge):
  - all FIFOs emptied, so valid_op = 0;
  - drop_cnt = 0, drop_pulse = 0;
  - in-flight and queued packets are discarded, with no output handshake completing in that cycle;
  - ready_up evaluates normally from the now-empty state.
- Classification (combinational on data_ip): tgt = target field. A packet is *illegal* if tgt >= NUM_PORTS, or if DROP_SELF==1 and source == target.
- ready_up (combinational):
  - 1 if the packet is illegal;
  - otherwise equals !full[tgt];
  - forced 0 while reset is high;
  - depends only on registered FIFO state and data_ip, never on ready_op, so a pop in the same cycle does not free space for a push to a full FIFO.
- Accept occurs when valid_up && ready_up at a rising edge.
  - Legal packet: written to FIFO[tgt] tail; occupancy +1.
  - Illegal packet: discarded. drop_pulse = 1 in the following cycle; drop_cnt increments, holding at 2**CNT_W-1.
- Latency: a legal packet accepted at edge N into an empty FIFO gives valid_op[tgt] = 1 with that packet on data_op from just after edge N; first possible pop is at edge N+1.
- Output port p:
  - valid_op[p] = !empty[p]; data_op slice = FIFO head (registered storage, no bubbles);
  - pop when valid_op[p] && ready_op[p] at an edge; the next entry is visible the following cycle;
  - ports are fully independent, so any subset may pop in the same cycle;
  - data_op slice is don't-care while valid_op[p] = 0; the bench must not check it.
- Simultaneous push and pop on the same non-full, non-empty FIFO: both take effect; occupancy unchanged; order preserved.
- Simultaneous push and pop on an empty FIFO: push only, since valid was 0.
- Full FIFO: push is refused (ready_up = 0); upstream must hold data_ip/valid_up stable until accepted. Other targets are unaffected.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The occupancy counter is log2(DEPTH)+1 bits; full is occupancy == DEPTH, empty is occupancy == 0.
- FIFO order: strict FIFO per port; no ordering guarantee across ports.
- Upstream protocol: valid_up may drop without acceptance (no-stall source permitted); the switch never buffers unaccepted data.

Test Plan:
1. Reset, then drive {src=1, tgt=2, data=8'hA5} for one cycle -> ready_up = 1; next cycle valid_op = 4'b0100 and port 2 data = 16'h12A5; ready_op[2] = 1 pops it and valid_op[2] = 0 the following cycle.
2. ready_op = 0; push 5 packets to tgt=0 with data 1..5 -> first 4 accepted, ready_up = 0 on the 5th (held); raise ready_op[0] -> 5th accepted one cycle after the first pop; outputs read 1, 2, 3, 4, 5 in order.
3. DROP_SELF = 1, NUM_PORTS = 4: send tgt=7, then src=3/tgt=3, then src=1/tgt=3 -> two drop_pulse cycles, drop_cnt = 2, and only the third packet appears on port 3.
4. Fill port 1 to 2 entries, then push one and pop one in the same cycle for 10 cycles with an incrementing payload -> occupancy stays 2, pointers wrap, payload order is intact.
5. CNT_W = 2: send 5 illegal packets -> drop_cnt reads 1, 2, 3, 3, 3.
6. With 3 packets queued on ports 0 and 3, assert reset for one cycle mid-stream -> valid_op = 0 and drop_cnt = 0 next cycle; a fresh packet then routes normally.
